// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Shared definitions for the Game-of-Life engine: default board geometry,
// the sequencer state encoding and the toroidal neighbour-index helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package life_pkg;

   localparam int ROWS_DEF = 16;
   localparam int COLS_DEF = 16;
   localparam int FPG_DEF  = 30;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_COMMIT  = 2'd2
   } life_state_e;

   // Index of the neighbour before i on a ring of n cells.
   function automatic int wrap_dec(input int i, input int n);
      return (i == 0) ? n - 1 : i - 1;
   endfunction

   // Index of the neighbour after i on a ring of n cells.
   function automatic int wrap_inc(input int i, input int n);
      return (i == n - 1) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/life_row_next.sv
// -----------------------------------------------------------------------------
// life_row_next
// Purely combinational B3/S23 evaluation of one board row. Counts the eight
// neighbours of every cell using the rows above and below, with the column
// index wrapping around the board edge.
// Ports:
//   above_i  : row r-1 (already wrapped by the caller)
//   centre_i : row r
//   below_i  : row r+1 (already wrapped by the caller)
//   next_o   : row r of the next generation
// -----------------------------------------------------------------------------
module life_row_next
   import life_pkg::*;
#(
   parameter int COLS = COLS_DEF
) (
   input  logic [COLS-1:0] above_i,
   input  logic [COLS-1:0] centre_i,
   input  logic [COLS-1:0] below_i,
   output logic [COLS-1:0] next_o
);

   logic [3:0] cnt;

   always_comb begin
      // NOTE: every variable gets a default at the top of the block so no
      // path leaves it unassigned; that is what keeps this free of latches.
      next_o = '0;
      cnt    = '0;
      for (int c = 0; c < COLS; c++) begin
         cnt = 4'(above_i[wrap_dec(c, COLS)])  + 4'(above_i[c])  + 4'(above_i[wrap_inc(c, COLS)])
             + 4'(centre_i[wrap_dec(c, COLS)])                   + 4'(centre_i[wrap_inc(c, COLS)])
             + 4'(below_i[wrap_dec(c, COLS)])  + 4'(below_i[c])  + 4'(below_i[wrap_inc(c, COLS)]);
         // Born on 3; survives on 2 or 3.
         next_o[c] = (cnt == 4'd3) || (centre_i[c] && (cnt == 4'd2));
      end
   end

endmodule

// File: rtl/life_engine.sv
// -----------------------------------------------------------------------------
// life_engine
// Double-buffered Game-of-Life board. The displayed board (cur) is only
// replaced in the single COMMIT cycle, so a frame never shows a partially
// computed generation. One row of the scratch board (nxt) is computed per
// COMPUTE cycle.
// Ports:
//   clk, rst               : pixel clock, async active-high reset
//   frame_tick             : one-cycle pulse per video frame
//   run                    : auto-advance every FRAMES_PER_GEN frames
//   step                   : one-cycle pulse, advance one generation
//   load_en/row/col/val    : single-cell write of cur, honoured only when idle
//   rd_row, rd_col         : renderer read address
//   rd_alive               : registered cell value (0 when out of range)
//   busy                   : high while computing or committing
//   gen_count              : generations committed since reset (wraps)
// Board dimensions must not exceed 32 since the index ports are 5 bits wide.
// -----------------------------------------------------------------------------
module life_engine
   import life_pkg::*;
#(
   parameter int ROWS           = ROWS_DEF,
   parameter int COLS           = COLS_DEF,
   parameter int FRAMES_PER_GEN = FPG_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        run,
   input  logic        step,
   input  logic        load_en,
   input  logic [4:0]  load_row,
   input  logic [4:0]  load_col,
   input  logic        load_val,
   input  logic [4:0]  rd_row,
   input  logic [4:0]  rd_col,
   output logic        rd_alive,
   output logic        busy,
   output logic [15:0] gen_count
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

   life_state_e               state_q;
   logic [RW-1:0]             row_q;
   logic [FW-1:0]             fc_q, fc_d;
   logic [ROWS-1:0][COLS-1:0] cur_q, nxt_q;
   logic                      rd_alive_q, busy_q;
   logic [15:0]               gen_q;

   logic                      run_trig, trigger, rd_bit;
   logic [COLS-1:0]           above, centre, below, next_row;

   // Frame counter keeps running while busy; a wrap that lands while busy is
   // simply not acted on by the FSM.
   always_comb begin
      fc_d     = fc_q;
      run_trig = 1'b0;
      if (!run) begin
         fc_d = '0;
      end else if (frame_tick) begin
         if (fc_q == FW'(FRAMES_PER_GEN - 1)) begin
            fc_d     = '0;
            run_trig = 1'b1;
         end else begin
            fc_d = fc_q + FW'(1);
         end
      end
   end

   // step and a run wrap in the same cycle collapse into one trigger.
   assign trigger = step || run_trig;

   // Select the three source rows around row_q, wrapping top/bottom.
   always_comb begin
      above  = '0;
      centre = '0;
      below  = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_q == RW'(r)) begin
            above  = cur_q[wrap_dec(r, ROWS)];
            centre = cur_q[r];
            below  = cur_q[wrap_inc(r, ROWS)];
         end
      end
   end

   life_row_next #(.COLS(COLS)) u_row_next (
      .above_i  (above),
      .centre_i (centre),
      .below_i  (below),
      .next_o   (next_row)
   );

   // Read decode; any index outside the board matches nothing and reads 0.
   always_comb begin
      rd_bit = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (rd_row == 5'(r) && rd_col == 5'(c)) rd_bit = cur_q[r][c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: both boards are plain flops rather than a RAM, so they can
         // and do clear on reset; an abort mid-compute leaves nothing behind.
         state_q    <= ST_IDLE;
         row_q      <= '0;
         fc_q       <= '0;
         cur_q      <= '0;
         nxt_q      <= '0;
         rd_alive_q <= 1'b0;
         busy_q     <= 1'b0;
         gen_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every read in this
         // block sees the pre-edge value (e.g. the COMMIT copy of nxt_q).
         fc_q       <= fc_d;
         rd_alive_q <= rd_bit;
         case (state_q)
            ST_IDLE: begin
               if (load_en) begin
                  for (int r = 0; r < ROWS; r++) begin
                     for (int c = 0; c < COLS; c++) begin
                        if (load_row == 5'(r) && load_col == 5'(c)) cur_q[r][c] <= load_val;
                     end
                  end
               end
               if (trigger) begin
                  state_q <= ST_COMPUTE;
                  row_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_COMPUTE: begin
               for (int r = 0; r < ROWS; r++) begin
                  if (row_q == RW'(r)) nxt_q[r] <= next_row;
               end
               if (row_q == RW'(ROWS - 1)) state_q <= ST_COMMIT;
               else                        row_q   <= row_q + RW'(1);
            end
            ST_COMMIT: begin
               cur_q   <= nxt_q;
               gen_q   <= gen_q + 16'd1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_alive  = rd_alive_q;
   assign busy      = busy_q;
   assign gen_count = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// -----------------------------------------------------------------------------
// tb_life_engine
// Self-checking bench for life_engine. A behavioural board model applies the
// B3/S23 rule with modular (toroidal) arithmetic; every generation and every
// board read is compared against it.
// -----------------------------------------------------------------------------
module tb_life_engine;

   localparam int ROWS     = 16;
   localparam int COLS     = 16;
   localparam int FPG      = 2;
   localparam int BUSY_CYC = ROWS + 1;

   logic        clk, rst;
   logic        frame_tick, run, step, load_en, load_val;
   logic [4:0]  load_row, load_col, rd_row, rd_col;
   logic        rd_alive, busy;
   logic [15:0] gen_count;

   int          n_vec, n_err;
   bit          model [ROWS][COLS];
   logic [15:0] gen_exp;

   life_engine #(.ROWS(ROWS), .COLS(COLS), .FRAMES_PER_GEN(FPG)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .run        (run),
      .step       (step),
      .load_en    (load_en),
      .load_row   (load_row),
      .load_col   (load_col),
      .load_val   (load_val),
      .rd_row     (rd_row),
      .rd_col     (rd_col),
      .rd_alive   (rd_alive),
      .busy       (busy),
      .gen_count  (gen_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) model[r][c] = 1'b0;
      gen_exp = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      clear_model();
      cyc();
   endtask

   task automatic load(input int r, input int c, input bit v);
      load_en  = 1'b1;
      load_row = 5'(r);
      load_col = 5'(c);
      load_val = v;
      cyc();
      load_en = 1'b0;
      if (r < ROWS && c < COLS) model[r][c] = v;
   endtask

   // One generation by the rule, with neighbour coordinates taken mod size.
   function automatic void model_gen();
      bit nb [ROWS][COLS];
      int n;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0)
                     n += int'(model[(r + dr + ROWS) % ROWS][(c + dc + COLS) % COLS]);
            nb[r][c] = model[r][c] ? (n == 2 || n == 3) : (n == 3);
         end
      end
      model   = nb;
      gen_exp = gen_exp + 16'd1;
   endfunction

   task automatic compare_board(input string tag);
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            rd_row = 5'(r);
            rd_col = 5'(c);
            cyc();
            check($sformatf("%s(%0d,%0d)", tag, r, c), rd_alive, model[r][c]);
         end
      end
   endtask

   // Called right after the edge that sampled a trigger. Follows the busy
   // window (bounded), checks reads still show the old board, optionally
   // injects frame ticks / steps / a (3,3) load at given busy-cycle indices.
   task automatic finish_gen(input logic [63:0] tick_m, input logic [63:0] step_m,
                             input logic [63:0] load_m);
      bit old [ROWS][COLS];
      int cycles, rr, cc;
      old = model;
      check("busy_rise", busy, 1);
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         rr         = int'($urandom_range(ROWS - 1));
         cc         = int'($urandom_range(COLS - 1));
         rd_row     = 5'(rr);
         rd_col     = 5'(cc);
         frame_tick = tick_m[cycles];
         step       = step_m[cycles];
         load_en    = load_m[cycles];
         load_row   = 5'd3;
         load_col   = 5'd3;
         load_val   = 1'b1;
         cyc();
         frame_tick = 1'b0;
         step       = 1'b0;
         load_en    = 1'b0;
         cycles++;
         check($sformatf("rd_old(%0d,%0d)", rr, cc), rd_alive, old[rr][cc]);
      end
      check("busy_cycles", cycles, BUSY_CYC);
      model_gen();
      check("gen_count", gen_count, gen_exp);
   endtask

   task automatic pulse_step();
      step = 1'b1;
      cyc();
      step = 1'b0;
      finish_gen('0, '0, '0);
   endtask

   task automatic tick_frame();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   bit glider_init [ROWS][COLS];

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1; frame_tick = 1'b0; run = 1'b0; step = 1'b0;
      load_en = 1'b0; load_val = 1'b0; load_row = '0; load_col = '0;
      rd_row = '0; rd_col = '0;
      clear_model();
      cyc();
      cyc();
      rst = 1'b0;
      cyc();

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_gen", gen_count, 0);
      check("rst_rd", rd_alive, 0);
      compare_board("rst_board");

      // Read path and out-of-range handling
      load(0, 15, 1'b1);
      rd_row = 5'd0; rd_col = 5'd15;
      cyc();
      check("rd_0_15", rd_alive, 1);
      rd_col = 5'd16;
      cyc();
      check("rd_col16", rd_alive, 0);
      load(0, 15, 1'b0);
      load(16, 0, 1'b1);
      load(0, 16, 1'b1);
      load(31, 31, 1'b1);
      compare_board("oor_load");

      // Blinker
      load(7, 6, 1'b1);
      load(7, 7, 1'b1);
      load(7, 8, 1'b1);
      pulse_step();
      compare_board("blinker1");
      pulse_step();
      compare_board("blinker2");

      // step and load during COMPUTE are dropped
      step = 1'b1;
      cyc();
      step = 1'b0;
      finish_gen('0, 64'd1 << 3, 64'd1 << 3);
      cyc();
      check("no_queued_step", busy, 0);
      cyc();
      check("gen_after_drop", gen_count, gen_exp);
      compare_board("busy_drop");

      // Reset mid-compute at row 5
      step = 1'b1;
      cyc();
      step = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_gen", gen_count, 0);
      cyc();
      rst = 1'b0;
      clear_model();
      rd_row = 5'd7; rd_col = 5'd7;
      cyc();
      check("midrst_rd", rd_alive, 0);
      compare_board("midrst_board");

      // Glider across the wrap, 64 generations back home
      load(14, 15, 1'b1);
      load(15, 0, 1'b1);
      load(0, 14, 1'b1);
      load(0, 15, 1'b1);
      load(0, 0, 1'b1);
      glider_init = model;
      for (int i = 1; i <= 64; i++) begin
         pulse_step();
         if (i % 16 == 0) compare_board($sformatf("glider%0d", i));
      end
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            rd_row = 5'(r);
            rd_col = 5'(c);
            cyc();
            check($sformatf("glider_home(%0d,%0d)", r, c), rd_alive, glider_init[r][c]);
         end
      end
      check("glider_gen", gen_count, 64);

      // Run cadence: every 2nd tick triggers
      do_reset();
      load(7, 6, 1'b1);
      load(7, 7, 1'b1);
      load(7, 8, 1'b1);
      run = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick_frame();
         if (t % 2 == 0) finish_gen('0, '0, '0);
         else            check($sformatf("no_trig_tick%0d", t), busy, 0);
         cyc();
         cyc();
      end
      check("run_gen3", gen_count, 3);

      // Tick 7 counts, tick 8 triggers, ticks 9/10 arrive while busy: 10 is lost
      tick_frame();
      check("tick7", busy, 0);
      tick_frame();
      finish_gen((64'd1 << 2) | (64'd1 << 5), '0, '0);
      cyc();
      check("lost_trig_busy", busy, 0);
      cyc();
      check("lost_trig_gen", gen_count, gen_exp);
      tick_frame();
      check("tick11", busy, 0);
      tick_frame();
      finish_gen('0, '0, '0);

      // step and run trigger together: one generation only
      cyc();
      tick_frame();
      check("tick13", busy, 0);
      frame_tick = 1'b1;
      step = 1'b1;
      cyc();
      frame_tick = 1'b0;
      step = 1'b0;
      finish_gen('0, '0, '0);
      cyc();
      check("no_double_busy", busy, 0);
      cyc();
      check("no_double_gen", gen_count, gen_exp);

      // run=0 holds the counter at 0 and ticks do nothing
      tick_frame();
      check("tick15", busy, 0);
      run = 1'b0;
      for (int t = 0; t < 3; t++) begin
         tick_frame();
         check($sformatf("run0_tick%0d", t), busy, 0);
         cyc();
      end
      check("run0_gen", gen_count, gen_exp);
      run = 1'b1;
      tick_frame();
      check("rerun_tick1", busy, 0);
      tick_frame();
      finish_gen('0, '0, '0);
      run = 1'b0;
      compare_board("run_board");

      // Random boards against the model
      for (int k = 0; k < 3; k++) begin
         do_reset();
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               if ($urandom_range(2) == 0) load(r, c, 1'b1);
         for (int j = 0; j < 4; j++)
            load(ROWS + int'($urandom_range(31 - ROWS)), int'($urandom_range(31)), 1'b1);
         for (int g = 0; g < 2; g++) begin
            pulse_step();
            compare_board($sformatf("rand%0d_g%0d", k, g));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/life_engine.md
# life_engine

Game-of-Life state engine that holds the ROWS×COLS cell board and advances it one generation at a time under the B3/S23 rule with toroidal wrap-around. Sits directly upstream of the VGA display controller's pixel path. The renderer converts the controller's beam position into a cell coordinate, reads this block's `rd_alive`, and gates colour with `bright`. The board is double-buffered: the displayed board only changes in a single commit cycle, so a frame never shows a half-computed generation.

## Interface
Parameters:
- `ROWS`, default 16: board height in cells.
- `COLS`, default 16: board width in cells.
- `FRAMES_PER_GEN`, default 30: frames between generations in run mode, ≥1.

Ports:
- `clk`, in, 1: pixel-domain clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per video frame, from the display side.
- `run`, in, 1: level; auto-advance enable.
- `step`, in, 1: one-cycle pulse; advance one generation.
- `load_en`, in, 1: write one cell of the current board.
- `load_row`, in, 5: write row index.
- `load_col`, in, 5: write column index.
- `load_val`, in, 1: value written.
- `rd_row`, in, 5: renderer read row.
- `rd_col`, in, 5: renderer read column.
- `rd_alive`, out, 1: registered state of cell (`rd_row`, `rd_col`) on the current board.
- `busy`, out, 1: high while computing or committing.
- `gen_count`, out, 16: generations committed since reset.

## Operation
- Boards:
  - `cur` is the displayed and read board; `nxt` is scratch. Both are ROWS×COLS bits.
  - Reset clears both boards, the frame counter, `gen_count`, `rd_alive` and `busy`; the FSM resets to IDLE.
- FSM states: IDLE, COMPUTE, COMMIT.
- IDLE:
  - A trigger moves the FSM to COMPUTE with the row counter at 0.
  - A trigger is `step`, or `run` && `frame_tick` && frame counter == FRAMES_PER_GEN-1.
- COMPUTE:
  - Each cycle, row r of `nxt` is computed from `cur` rows r-1, r and r+1, mod ROWS; columns wrap mod COLS.
  - Rule: a live cell with 2 or 3 live neighbours lives; a dead cell with exactly 3 lives; every other cell dies.
  - After row ROWS-1 the FSM goes to COMMIT.
- COMMIT:
  - `cur` ← `nxt` and `gen_count` += 1, wrapping 0xFFFF→0.
  - The FSM returns to IDLE.
- Frame counter:
  - Increments on each `frame_tick` while `run`=1.
  - Wraps to 0 at FRAMES_PER_GEN-1; that is the trigger tick.
  - Held at 0 while `run`=0.
  - Keeps counting while busy; a trigger tick that arrives while busy is lost.
- Loads:
  - `load_en` writes `cur` only in IDLE; it is ignored while busy.
  - Out-of-range indices (≥ROWS or ≥COLS) are ignored.
  - A load and a trigger in the same IDLE cycle: the write lands in that cycle, and COMPUTE, starting next cycle, sees the written value.
- Reads:
  - `rd_alive` registers `cur` at (`rd_row`, `rd_col`) every cycle, valid in every state.
  - Out-of-range read indices return 0.
- `step` while busy is dropped, not queued.
- `step` and a run trigger in the same IDLE cycle produce one generation, not two.

## Timing
- Trigger sampled at edge T → `busy`=1 from T+1.
- COMPUTE occupies edges T+1..T+ROWS; COMMIT is at edge T+ROWS+1.
- New `cur`, the incremented `gen_count` and `busy`=0 are all visible after edge T+ROWS+1: a total of ROWS+1 busy cycles (17 at the default).
- `rd_alive` latency is 1 cycle from the address. It reflects the new board starting with the read sampled at edge T+ROWS+2.
- Asserting `rst` mid-COMPUTE aborts immediately to the reset state. No partial commit is visible.

## Structure
- Shared package `life_pkg`:
  - ROWS/COLS defaults.
  - FSM state encoding (IDLE=2'd0, COMPUTE=2'd1, COMMIT=2'd2).
  - Neighbour-wrap index helpers.
- Sub-module `life_row_next`:
  - Purely combinational.
  - Takes the three COLS-bit rows (above, centre, below) and returns the COLS-bit next row.
  - Performs per-cell neighbour counting with column wrap.
  - Instantiated once; this block supplies the row selection and owns all state.

## Test plan
- Blinker: load (7,6),(7,7),(7,8); pulse `step` → after 17 busy cycles, cells (6,7),(7,7),(8,7) alive, row-7 ends dead, `gen_count`=1; a second step restores the horizontal bar with `gen_count`=2.
- Glider wrap: glider near (15,15); 64 steps → identical pattern back at its start cells (toroidal wrap), `gen_count`=64.
- Run cadence: FRAMES_PER_GEN=2, `run`=1, 6 `frame_tick` pulses → exactly 3 generations, each beginning the cycle after the 2nd, 4th and 6th tick; `run`=0 → ticks cause no generation.
- Busy drops: `step` and `load_en` (3,3)=1 during COMPUTE → no second generation, (3,3) unchanged after commit.
- Reset mid-compute: assert `rst` at COMPUTE row 5 → `busy`=0, all cells 0, `gen_count`=0, `rd_alive`=0 on next read.
- Read path: set (0,15)=1, `rd_row`=0, `rd_col`=15 → `rd_alive`=1 one cycle later; `rd_col`=16 → 0. During COMPUTE, `rd_alive` shows the old board until COMMIT.
